// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the ALU requester, bit 1 the memory unit.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e rr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (rr == REQ_ALU) ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when both asked, so a lone requester never loses its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= REQ_ALU;
        end else if (req == 2'b11) begin
            rr <= (rr == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler with RAW/WAW hazard scoreboard.
// Optional issue-time bypass of the granted writeback enabled by RF_BYPASS_EN.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic [ADDR_W-1:0]          issue_rs1,
    input  logic [ADDR_W-1:0]          issue_rs2,
    output logic                       issue_stall,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       write_reg,
    output logic [ADDR_W-1:0]          write_reg_addr,
    output logic [DATA_W-1:0]          write_reg_data,
    output logic [(1 << ADDR_W)-1:0]   busy,
    output logic                       byp_rs1_hit,
    output logic                       byp_rs2_hit,
    output logic [DATA_W-1:0]          byp_data
);

    wb_req_t                   alu_req;
    wb_req_t                   mem_req;
    wb_req_t                   win;
    logic [1:0]                req;
    logic [1:0]                gnt;
    logic                      wr_en;
    logic                      accept;
    logic [(1 << ADDR_W)-1:0]  busy_next;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};
    assign req     = {mem_req.valid, alu_req.valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];

    always_comb begin
        win = alu_req;
        if (gnt[1]) begin
            win = mem_req;
        end
        win.valid = |gnt;
    end

    // r0 grants complete the handshake but never reach the file or scoreboard.
    assign wr_en = win.valid && (win.rd != '0);

`ifdef RF_BYPASS_EN
    logic byp_ok;

    assign byp_ok      = wr_en && busy[win.rd];
    assign byp_rs1_hit = issue_valid && byp_ok && (issue_rs1 == win.rd);
    assign byp_rs2_hit = issue_valid && byp_ok && (issue_rs2 == win.rd);
    assign byp_data    = (byp_rs1_hit || byp_rs2_hit) ? win.data : '0;
`else
    assign byp_rs1_hit = 1'b0;
    assign byp_rs2_hit = 1'b0;
    assign byp_data    = '0;
`endif

    assign issue_stall = issue_valid && ((busy[issue_rs1] && !byp_rs1_hit) ||
                                         (busy[issue_rs2] && !byp_rs2_hit) ||
                                         busy[issue_rd]);
    assign accept      = issue_valid && !issue_stall && (issue_rd != '0);

    // WAW stall keeps set and clear off the same bit in one cycle.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[win.rd] = 1'b0;
        end
        if (accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= '0;
            write_reg      <= 1'b0;
            write_reg_addr <= '0;
            write_reg_data <= '0;
        end else begin
            busy      <= busy_next;
            write_reg <= wr_en;
            if (wr_en) begin
                write_reg_addr <= win.rd;
                write_reg_data <= win.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed scenarios plus a randomized run against a reference model.
module tb_rf_write_sched;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_valid = 1'b0;
    logic [4:0]        issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic              issue_stall;
    logic              alu_valid = 1'b0, mem_valid = 1'b0;
    logic              alu_ready, mem_ready;
    logic [4:0]        alu_rd = '0, mem_rd = '0;
    logic [31:0]       alu_data = '0, mem_data = '0;
    logic              write_reg;
    logic [4:0]        write_reg_addr;
    logic [31:0]       write_reg_data;
    logic [31:0]       busy;
    logic              byp_rs1_hit, byp_rs2_hit;
    logic [31:0]       byp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_write_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_stall    (issue_stall),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .write_reg      (write_reg),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .busy           (busy),
        .byp_rs1_hit    (byp_rs1_hit),
        .byp_rs2_hit    (byp_rs2_hit),
        .byp_data       (byp_data)
    );

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        issue_valid = 1'b1; issue_rd = 5'd6;
        @(posedge clk); #1;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0055;
        @(posedge clk); #1;
        tests++;
        if (write_reg !== 1'b1 || busy !== 32'h0000_0040) begin
            fails++;
            $display("FAIL reset_pre: write_reg=%b busy=%h, required 1 / 00000040", write_reg, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (write_reg !== 1'b0 || write_reg_addr !== 5'd0 || write_reg_data !== 32'd0 ||
            busy !== 32'd0) begin
            fails++;
            $display("FAIL reset_async: we=%b addr=%0d data=%h busy=%h, required all 0",
                     write_reg, write_reg_addr, write_reg_data, busy);
        end
        alu_valid = 1'b0;
        tests++;
        if (byp_rs1_hit !== 1'b0 || byp_rs2_hit !== 1'b0 || byp_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_byp: hit1=%b hit2=%b data=%h, required 0", byp_rs1_hit, byp_rs2_hit, byp_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; mem_valid = 1'b1; mem_rd = 5'd4;
        @(negedge clk);
        tests++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || busy !== 32'd0) begin
            fails++;
            $display("FAIL reset_first_contest: alu_rdy=%b mem_rdy=%b busy=%h, required 1 0 0",
                     alu_ready, mem_ready, busy);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_raw();
        apply_reset();
        issue_valid = 1'b1; issue_rd = 5'd5;
        @(negedge clk);
        tests++;
        if (issue_stall !== 1'b0) begin
            fails++;
            $display("FAIL raw_first_issue: stall=%b, required 0", issue_stall);
        end
        @(posedge clk); #1;
        issue_rd = 5'd0; issue_rs1 = 5'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (issue_stall !== 1'b1) begin
                fails++;
                $display("FAIL raw_stall_%0d: stall=%b, required 1", i, issue_stall);
            end
            @(posedge clk); #1;
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
`ifdef RF_BYPASS_EN
        if (alu_ready !== 1'b1 || issue_stall !== 1'b0 || byp_rs1_hit !== 1'b1) begin
            fails++;
            $display("FAIL raw_grant_cycle: rdy=%b stall=%b hit1=%b, required 1 0 1", alu_ready, issue_stall, byp_rs1_hit);
        end
`else
        if (alu_ready !== 1'b1 || issue_stall !== 1'b1) begin
            fails++;
            $display("FAIL raw_grant_cycle: rdy=%b stall=%b, required 1 1", alu_ready, issue_stall);
        end
`endif
        @(posedge clk); #1;
        alu_valid = 1'b0;
        tests++;
        if (write_reg !== 1'b1 || write_reg_addr !== 5'd5 || write_reg_data !== 32'hDEAD_BEEF ||
            busy[5] !== 1'b0) begin
            fails++;
            $display("FAIL raw_write: we=%b addr=%0d data=%h busy5=%b, required 1 5 deadbeef 0",
                     write_reg, write_reg_addr, write_reg_data, busy[5]);
        end
        @(negedge clk);
        tests++;
        if (issue_stall !== 1'b0) begin
            fails++;
            $display("FAIL raw_release: stall=%b, required 0", issue_stall);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_alu;
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h4444_4444;
        for (int i = 0; i < 4; i++) begin
            exp_alu = (i % 2 == 0);
            @(negedge clk);
            tests++;
            if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
                fails++;
                $display("FAIL alt_grant_%0d: alu_rdy=%b mem_rdy=%b, required %b %b",
                         i, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            @(posedge clk); #1;
            tests++;
            if (write_reg !== 1'b1 || write_reg_addr !== (exp_alu ? 5'd3 : 5'd4) ||
                write_reg_data !== (exp_alu ? 32'h3333_3333 : 32'h4444_4444)) begin
                fails++;
                $display("FAIL alt_write_%0d: we=%b addr=%0d data=%h", i, write_reg, write_reg_addr, write_reg_data);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        tests++;
        if (write_reg !== 1'b0 || write_reg_addr !== 5'd4) begin
            fails++;
            $display("FAIL idle_hold: we=%b addr=%0d, required 0 4", write_reg, write_reg_addr);
        end
    endtask

    task automatic test_rd_zero();
        apply_reset();
        issue_valid = 1'b1; issue_rd = 5'd10;
        @(posedge clk); #1;
        issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        @(negedge clk);
        tests++;
        if (alu_ready !== 1'b1 || issue_stall !== 1'b0) begin
            fails++;
            $display("FAIL rd0_handshake: rdy=%b stall=%b, required 1 0", alu_ready, issue_stall);
        end
        @(posedge clk); #1;
        tests++;
        if (write_reg !== 1'b0 || busy !== 32'h0000_0400) begin
            fails++;
            $display("FAIL rd0_nowrite: we=%b busy=%h, required 0 00000400", write_reg, busy);
        end
        idle_inputs();
    endtask

    task automatic test_waw();
        apply_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (issue_stall !== 1'b1) begin
            fails++;
            $display("FAIL waw_stall: stall=%b, required 1", issue_stall);
        end
        @(posedge clk); #1;
        issue_rd = 5'd8;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777_0007;
        @(negedge clk);
        tests++;
        if (issue_stall !== 1'b0 || mem_ready !== 1'b1) begin
            fails++;
            $display("FAIL waw_overlap: stall=%b mem_rdy=%b, required 0 1", issue_stall, mem_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (busy[8] !== 1'b1 || busy[7] !== 1'b0) begin
            fails++;
            $display("FAIL waw_set_clear: busy8=%b busy7=%b, required 1 0", busy[8], busy[7]);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        apply_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(posedge clk); #1;
        issue_rd = 5'd0; issue_rs2 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5_A5A5;
        @(negedge clk);
        tests++;
`ifdef RF_BYPASS_EN
        if (issue_stall !== 1'b0 || byp_rs2_hit !== 1'b1 || byp_rs1_hit !== 1'b0 ||
            byp_data !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL bypass_hit: stall=%b hit1=%b hit2=%b data=%h, required 0 0 1 a5a5a5a5",
                     issue_stall, byp_rs1_hit, byp_rs2_hit, byp_data);
        end
`else
        if (issue_stall !== 1'b1 || byp_rs2_hit !== 1'b0 || byp_data !== 32'd0) begin
            fails++;
            $display("FAIL bypass_off: stall=%b hit2=%b data=%h, required 1 0 0",
                     issue_stall, byp_rs2_hit, byp_data);
        end
`endif
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (issue_stall !== 1'b0) begin
            fails++;
            $display("FAIL bypass_after: stall=%b, required 0", issue_stall);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Model: a set of pending destinations; contested grants alternate starting with ALU after reset.
    task automatic test_random();
        bit [31:0] m_busy;
        int        contested;
        bit        ga, gm, g, exp_we, hit1, hit2, exp_stall;
        bit [4:0]  w_rd;
        bit [31:0] w_data, exp_byp;
        apply_reset();
        m_busy = '0;
        contested = 0;
        ga = 1'b0; gm = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(alu_valid && !ga)) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd = 5'($urandom_range(0, 7));
                alu_data = $urandom;
            end
            if (!(mem_valid && !gm)) begin
                mem_valid = ($urandom_range(0, 1) == 1);
                mem_rd = 5'($urandom_range(0, 7));
                mem_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd  = 5'($urandom_range(0, 7));
            issue_rs1 = 5'($urandom_range(0, 7));
            issue_rs2 = 5'($urandom_range(0, 7));
            if ((alu_valid && alu_rd == issue_rd) || (mem_valid && mem_rd == issue_rd))
                issue_rd = 5'd0;

            @(negedge clk);
            ga = alu_valid && (!mem_valid || (contested % 2 == 0));
            gm = mem_valid && !ga;
            g = ga || gm;
            w_rd = ga ? alu_rd : mem_rd;
            w_data = ga ? alu_data : mem_data;
            exp_we = g && (w_rd != 5'd0);
`ifdef RF_BYPASS_EN
            hit1 = issue_valid && exp_we && m_busy[w_rd] && (issue_rs1 == w_rd);
            hit2 = issue_valid && exp_we && m_busy[w_rd] && (issue_rs2 == w_rd);
`else
            hit1 = 1'b0;
            hit2 = 1'b0;
`endif
            exp_byp = (hit1 || hit2) ? w_data : 32'd0;
            exp_stall = issue_valid && ((m_busy[issue_rs1] && !hit1) ||
                                        (m_busy[issue_rs2] && !hit2) || m_busy[issue_rd]);
            tests++;
            if (issue_stall !== exp_stall || alu_ready !== ga || mem_ready !== gm) begin
                fails++;
                $display("FAIL rand_comb_%0d: stall=%b rdy=%b%b, required %b %b%b",
                         n, issue_stall, alu_ready, mem_ready, exp_stall, ga, gm);
            end
            tests++;
            if (byp_rs1_hit !== hit1 || byp_rs2_hit !== hit2 || byp_data !== exp_byp) begin
                fails++;
                $display("FAIL rand_byp_%0d: hit=%b%b data=%h, required %b%b %h",
                         n, byp_rs1_hit, byp_rs2_hit, byp_data, hit1, hit2, exp_byp);
            end

            @(posedge clk); #1;
            if (exp_we) m_busy[w_rd] = 1'b0;
            if (issue_valid && !exp_stall && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (alu_valid && mem_valid) contested++;
            tests++;
            if (write_reg !== exp_we || (exp_we && (write_reg_addr !== w_rd || write_reg_data !== w_data))) begin
                fails++;
                $display("FAIL rand_write_%0d: we=%b addr=%0d data=%h, required %b %0d %h",
                         n, write_reg, write_reg_addr, write_reg_data, exp_we, w_rd, w_data);
            end
            tests++;
            if (busy !== m_busy) begin
                fails++;
                $display("FAIL rand_busy_%0d: busy=%h, required %h", n, busy, m_busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_back_to_back();
        test_rd_zero();
        test_waw();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
